bsg_link_isdr_rx: RTL

Receive-side front end of the source-synchronous SDR link. Captures the link word launched by the transmit PHY, runs in the forwarded-clock domain, and buffers words in a small FIFO with a valid/yumi consumer interface. Returns credits upstream as a toggling token wire, one toggle per `token_decim_p` words consumed. Sits between the pad-side clock/data buffers and the downstream async FIFO of the link.

---
 rtl/bsg_link_sdr_pkg.sv | 17 +
 rtl/bsg_link_isdr_rx_fifo.sv | 63 ++++++
 rtl/bsg_link_isdr_rx.sv | 116 +++++++++++
 3 files changed

// File: rtl/bsg_link_sdr_pkg.sv
// bsg_link_sdr_pkg
//   Constants shared by both ends of the source-synchronous SDR link. The
//   transmit credit counter and the receive FIFO/token logic both take their
//   defaults from here, so the two ends always agree on the credit count.
package bsg_link_sdr_pkg;

  localparam int unsigned link_width_lp       = 8;
  localparam int unsigned link_fifo_els_lp    = 4;
  localparam int unsigned link_token_decim_lp = 2;

  // Counter width for a modulus of x. Never returns less than one bit, so a
  // modulus of 1 still gives a legal (constant-zero) register.
  function automatic int unsigned lg_min1(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_link_isdr_rx_fifo.sv
// bsg_link_isdr_rx_fifo
//   Small circular FIFO behind the receive capture stage.
//   Ports:
//     clk_i, reset_i  forwarded link clock, synchronous active-high reset
//     enq_i, data_i   write data_i at the write pointer (caller ensures space)
//     deq_i           advance the read pointer (caller ensures not empty)
//     v_o, data_o     head valid / head word (no empty bypass)
//     full_o          count == els_p
module bsg_link_isdr_rx_fifo
  import bsg_link_sdr_pkg::*;
#(
  parameter int unsigned width_p = link_width_lp,
  parameter int unsigned els_p   = link_fifo_els_lp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               full_o
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);
  localparam int unsigned cnt_w_lp = ptr_w_lp + 1;

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + ptr_w_lp'(enq_i);
    rd_ptr_d = rd_ptr_q + ptr_w_lp'(deq_i);
    count_d  = count_q + cnt_w_lp'(enq_i) - cnt_w_lp'(deq_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (enq_i && !reset_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign v_o    = (count_q != '0);
  assign full_o = (count_q == cnt_w_lp'(els_p));
  assign data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/bsg_link_isdr_rx.sv
// bsg_link_isdr_rx
//   Receive front end of the SDR link, clocked by the forwarded link clock.
//   Captures v_i/data_i, buffers words in a small FIFO and returns credits
//   upstream as a toggle on token_o, one toggle per token_decim_p words taken.
//   Ports:
//     clk_i, reset_i     forwarded clock, synchronous active-high reset
//     v_i, data_i        link pins
//     v_o, data_o        FIFO head valid / word
//     yumi_i             consumer takes the head (only legal with v_o=1)
//     token_o            registered credit-return toggle
//     overflow_o         sticky: a valid word arrived with no FIFO space
module bsg_link_isdr_rx
  import bsg_link_sdr_pkg::*;
#(
  parameter int unsigned width_p       = link_width_lp,
  parameter int unsigned fifo_els_p    = link_fifo_els_lp,
  parameter int unsigned token_decim_p = link_token_decim_lp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               token_o,
  output logic               overflow_o
);

  localparam int unsigned tok_w_lp = lg_min1(token_decim_p);

  logic               v_r_q, v_r_d;
  logic [width_p-1:0] data_r_q, data_r_d;
  logic [tok_w_lp-1:0] tok_cnt_q, tok_cnt_d;
  logic               token_q, token_d;
  logic               overflow_q, overflow_d;

  logic fifo_v, fifo_full;
  logic yumi_ok, enq_ok, drop;

  // Capture stage: free-running, no enable, data flops not reset, so they
  // map onto the same cell style as the transmit PHY's launch flops.
  always_comb begin
    v_r_d    = v_i;
    data_r_d = data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) v_r_q <= 1'b0;
    else         v_r_q <= v_r_d;
  end

  always_ff @(posedge clk_i) begin
    data_r_q <= data_r_d;
  end

  // A yumi with an empty FIFO is ignored. A full FIFO still accepts a word
  // in the same cycle the head is taken.
  always_comb begin
    yumi_ok = yumi_i & fifo_v;
    enq_ok  = v_r_q & (~fifo_full | yumi_ok);
    drop    = v_r_q & fifo_full & ~yumi_ok;
  end

  bsg_link_isdr_rx_fifo #(
    .width_p (width_p),
    .els_p   (fifo_els_p)
  ) fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .enq_i   (enq_ok),
    .data_i  (data_r_q),
    .deq_i   (yumi_ok),
    .v_o     (fifo_v),
    .data_o  (data_o),
    .full_o  (fifo_full)
  );

  always_comb begin
    tok_cnt_d  = tok_cnt_q;
    token_d    = token_q;
    overflow_d = overflow_q | drop;
    if (yumi_ok) begin
      if (tok_cnt_q == tok_w_lp'(token_decim_p - 1)) begin
        tok_cnt_d = '0;
        token_d   = ~token_q;
      end else begin
        tok_cnt_d = tok_cnt_q + tok_w_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tok_cnt_q  <= '0;
      token_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      tok_cnt_q  <= tok_cnt_d;
      token_q    <= token_d;
      overflow_q <= overflow_d;
    end
  end

  assign v_o        = fifo_v;
  assign token_o    = token_q;
  assign overflow_o = overflow_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !fifo_v))
        else $warning("bsg_link_isdr_rx: yumi_i asserted while v_o=0; ignored");
    end
  end

endmodule
